// File: rtl/mult_sequencer_pkg.sv
// mult_sequencer_pkg: shared adder command codes and sequencer state encoding.
package mult_sequencer_pkg;
    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;
endpackage

// File: rtl/adder_subtracter.sv
// adder_subtracter: shared WIDTH-bit adder; command[0] selects subtract (A + ~B + 1).
module adder_subtracter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [2:0]       i_command,
    output logic [WIDTH-1:0] o_ans,
    output logic             o_carryout
);
    logic [WIDTH-1:0] w_b;
    assign w_b = i_command[0] ? ~i_op_b : i_op_b;
    assign {o_carryout, o_ans} = {1'b0, i_op_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_command[0]};
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: radix-2 shift-and-add unsigned multiplier driving an external shared adder.
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] add_opA,
    output logic [WIDTH-1:0] add_opB,
    output logic [2:0]       add_command,
    input  logic [WIDTH-1:0] add_ans,
    input  logic             add_carryout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    seq_state_t       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_m     <= multiplicand;
                    r_hi    <= '0;
                    r_lo    <= multiplier;
                    r_count <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    // carry re-enters as the new MSB so no product bit is lost
                    {r_hi, r_lo} <= {add_carryout, add_ans, r_lo[WIDTH-1:1]};
                    r_count      <= r_count + 1'b1;
                    if (r_count == LAST) r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign product_hi  = r_hi;
    assign product_lo  = r_lo;
    assign add_opA     = r_hi;
    assign add_opB     = (busy && r_lo[0]) ? r_m : '0;
    assign add_command = CMD_ADD;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: scoreboard bench for mult_sequencer with one shared adder_subtracter.
module tb_mult_sequencer;
    localparam int W = 32;

    logic         clk = 0;
    logic         reset = 1;
    logic         start = 0;
    logic [W-1:0] multiplicand = '0;
    logic [W-1:0] multiplier = '0;
    logic         busy, done;
    logic [W-1:0] product_hi, product_lo, add_opA, add_opB, add_ans;
    logic [2:0]   add_command;
    logic         add_carryout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [2*W-1:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mult_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done),
        .product_hi(product_hi), .product_lo(product_lo),
        .add_opA(add_opA), .add_opB(add_opB), .add_command(add_command),
        .add_ans(add_ans), .add_carryout(add_carryout)
    );

    adder_subtracter #(.WIDTH(W)) u_add (
        .i_op_a(add_opA), .i_op_b(add_opB), .i_command(add_command),
        .o_ans(add_ans), .o_carryout(add_carryout)
    );

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (busy) check("add_command", 64'(add_command), 64'd0);
            if (done) begin
                if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else check("product", {product_hi, product_lo}, sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q);
        @(negedge clk);
        start = 1;
        multiplicand = m;
        multiplier = q;
        sb.push_back(64'(m) * 64'(q));
        @(posedge clk);
        #1 start = 0;
        multiplicand = ~m;
        multiplier = ~q;
    endtask

    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
            if (busy) busy_cycles++;
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    int bc;
    int t_done[3];

    initial begin
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", {product_hi, product_lo}, 64'd0);
        check("rst_opB", 64'(add_opB), 64'd0);
        @(negedge clk);
        reset = 0;

        issue(3, 5);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_done(bc);
        check("busy_cycles", 64'(bc), 64'd32);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("product_hold", {product_hi, product_lo}, 64'd15);
        check("idle_opB", 64'(add_opB), 64'd0);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(bc);
        check("ff_hi", 64'(product_hi), 64'hFFFF_FFFE);
        check("ff_lo", 64'(product_lo), 64'h0000_0001);
        issue(32'h1234_5678, 32'h0); wait_done(bc);
        issue(32'h0, 32'hDEAD_BEEF); wait_done(bc);
        issue(32'h8000_0000, 32'd2); wait_done(bc);
        issue(32'hA5A5_1234, 32'h0F0F_9876); wait_done(bc);

        issue(100, 200);
        repeat (10) @(negedge clk);
        start = 1; multiplicand = 77; multiplier = 88;
        @(negedge clk);
        start = 0;
        wait_done(bc);
        start = 1; multiplicand = 55; multiplier = 66;
        @(posedge clk);
        #1 start = 0;
        check("done_start_ignored", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check("ignored_hold", {product_hi, product_lo}, 64'd20000);

        issue(9, 9);
        repeat (15) @(negedge clk);
        #2 reset = 1;
        #1;
        check("midrun_rst_product", {product_hi, product_lo}, 64'd0);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_done", 64'(done), 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 0;
        repeat (40) @(negedge clk);
        issue(7, 6); wait_done(bc);

        @(negedge clk);
        start = 1; multiplicand = 2; multiplier = 3;
        for (int k = 0; k < 3; k++) sb.push_back(64'd6);
        for (int k = 0; k < 3; k++) begin
            wait_done(bc);
            t_done[k] = cyc;
        end
        start = 0;
        check("b2b_interval0", 64'(t_done[1] - t_done[0]), 64'd34);
        check("b2b_interval1", 64'(t_done[2] - t_done[1]), 64'd34);
        repeat (40) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
